// File: rtl/atm.sv
// -----------------------------------------------------------------------------
// atm -- fixed-latency ATM transaction engine.
//
// Holds a 10-entry account table (16-bit PIN, 32-bit balance per entry) and
// runs one transaction every 4 clocks: IDLE -> AUTH -> OP -> DONE -> IDLE.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset (FSM and outputs only)
//   operation  3 = balance, 4 = withdraw, 5 = deposit, 6 = change PIN
//   acc_num    account number, valid 1..10
//   pin        entered PIN
//   newPin     replacement PIN for operation 6
//   amount     withdraw / deposit amount
//   language   display language (carried along, no effect on results)
//   balance    registered balance result of the last transaction
//   success    registered 1 = last transaction completed, 0 = rejected
//   state      current FSM state encoding (IDLE=7, AUTH=0, OP=1, DONE=2)
//
// Handshake: there is no valid/ready pair. Inputs are sampled on every edge
// that leaves IDLE, so a caller holding inputs steady gets back-to-back
// transactions; results appear on the OP -> DONE edge and hold until the
// next one.
// -----------------------------------------------------------------------------
module atm #(
    parameter logic [15:0] INIT_PIN [0:9] = '{
        16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
        16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
    },
    parameter logic [31:0] INIT_BAL [0:9] = '{
        32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000,
        32'd6000, 32'd7000, 32'd8000, 32'd9000, 32'd10000
    }
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  operation,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] newPin,
    input  logic [31:0] amount,
    input  logic        language,
    output logic [31:0] balance,
    output logic        success,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE = 3'd7,
        AUTH = 3'd0,
        OP   = 3'd1,
        DONE = 3'd2
    } state_t;

    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_DEPOSIT  = 3'd5;
    localparam logic [2:0] OP_CHPIN    = 3'd6;

    state_t cur_state, nxt_state;

    // Transaction inputs captured on the IDLE -> AUTH edge.
    logic [2:0]  op_q;
    logic [3:0]  acc_q;
    logic [15:0] pin_q;
    logic [15:0] new_pin_q;
    logic [31:0] amount_q;
    logic        lang_q;
    logic        auth_q;

    // Account table. Loaded with its power-up contents only; reset leaves it
    // alone so balances and changed PINs survive a reset.
    logic [15:0] pin_tab [0:9] = INIT_PIN;
    logic [31:0] bal_tab [0:9] = INIT_BAL;

    logic        acc_valid;
    logic [3:0]  idx;
    logic [15:0] cur_pin;
    logic [31:0] cur_bal;
    logic [32:0] sum;

    logic [31:0] res_bal;
    logic        res_succ;
    logic        bal_we;
    logic [31:0] bal_wdata;
    logic        pin_we;

    // Language only matters to a display path that is not part of this block.
    logic unused_lang;
    assign unused_lang = lang_q;

    assign acc_valid = (acc_q >= 4'd1) && (acc_q <= 4'd10);
    // Out-of-range accounts read entry 0; auth_q masks the result anyway.
    assign idx       = acc_valid ? (acc_q - 4'd1) : 4'd0;
    assign cur_pin   = pin_tab[idx];
    assign cur_bal   = bal_tab[idx];
    // 33-bit sum so the carry flags a deposit that would wrap.
    assign sum       = {1'b0, cur_bal} + {1'b0, amount_q};

    assign state     = cur_state;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        nxt_state = IDLE;
        unique case (cur_state)
            IDLE:    nxt_state = AUTH;
            AUTH:    nxt_state = OP;
            OP:      nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // ---------------- input capture and authentication ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= 3'd0;
            acc_q     <= 4'd0;
            pin_q     <= 16'd0;
            new_pin_q <= 16'd0;
            amount_q  <= 32'd0;
            lang_q    <= 1'b0;
            auth_q    <= 1'b0;
        end else begin
            if (cur_state == IDLE) begin
                op_q      <= operation;
                acc_q     <= acc_num;
                pin_q     <= pin;
                new_pin_q <= newPin;
                amount_q  <= amount;
                lang_q    <= language;
            end
            if (cur_state == AUTH) begin
                auth_q <= acc_valid && (pin_q == cur_pin);
            end
        end
    end

    // ---------------- operation result ----------------
    always_comb begin
        res_bal   = 32'd0;
        res_succ  = 1'b0;
        bal_we    = 1'b0;
        bal_wdata = cur_bal;
        pin_we    = 1'b0;
        if (auth_q) begin
            res_bal = cur_bal;
            unique case (op_q)
                OP_BALANCE: begin
                    res_succ = 1'b1;
                end
                OP_WITHDRAW: begin
                    if (amount_q <= cur_bal) begin
                        bal_wdata = cur_bal - amount_q;
                        bal_we    = 1'b1;
                        res_bal   = bal_wdata;
                        res_succ  = 1'b1;
                    end
                end
                OP_DEPOSIT: begin
                    if (!sum[32]) begin
                        bal_wdata = sum[31:0];
                        bal_we    = 1'b1;
                        res_bal   = bal_wdata;
                        res_succ  = 1'b1;
                    end
                end
                OP_CHPIN: begin
                    if ((new_pin_q >= 16'd1000) && (new_pin_q <= 16'd9999) &&
                        (new_pin_q != cur_pin)) begin
                        pin_we   = 1'b1;
                        res_succ = 1'b1;
                    end
                end
                default: begin
                    res_succ = 1'b0;
                end
            endcase
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            balance <= 32'd0;
            success <= 1'b0;
        end else if (cur_state == OP) begin
            balance <= res_bal;
            success <= res_succ;
        end
    end

    // ---------------- table update ----------------
    // Only the OP -> DONE edge writes; an asynchronous reset moves the FSM
    // out of OP first, so an aborted transaction never reaches the table.
    always_ff @(posedge clk) begin
        if (cur_state == OP) begin
            if (bal_we) begin
                bal_tab[idx] <= bal_wdata;
            end
            if (pin_we) begin
                pin_tab[idx] <= new_pin_q;
            end
        end
    end

endmodule

// File: tb/tb_atm.sv
// -----------------------------------------------------------------------------
// tb_atm -- self-checking bench for atm.
// Reference model: plain arrays of PINs and balances updated with the account
// rules; expected {success, balance} pairs pass through exp_q.
// -----------------------------------------------------------------------------
module tb_atm;

    logic        clk;
    logic        rst;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] newPin;
    logic [31:0] amount;
    logic        language;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

    atm dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (newPin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] m_pin [10];
    longint      m_bal [10];
    logic [32:0] exp_q [$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Result held on the outputs from the previous transaction.
    logic [31:0] prev_bal;
    logic        prev_succ;
    logic        prev_bal_known;

    task automatic model_init();
        m_pin = '{16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
                  16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123};
        for (int n = 1; n <= 10; n++) m_bal[n-1] = 1000 * n;
    endtask

    task automatic model_txn(input logic [2:0] op, input logic [3:0] acc,
                             input logic [15:0] p, input logic [15:0] np,
                             input logic [31:0] amt,
                             output logic [32:0] r, output logic auth_ok);
        int     i;
        longint b;
        longint a;
        auth_ok = 1'b0;
        r = {1'b0, 32'd0};
        if (acc >= 1 && acc <= 10) begin
            i = int'(acc) - 1;
            if (p == m_pin[i]) auth_ok = 1'b1;
        end
        if (auth_ok) begin
            b = m_bal[i];
            a = longint'(amt);
            r = {1'b0, 32'(b)};
            case (op)
                3'd3: r = {1'b1, 32'(b)};
                3'd4: if (a <= b) begin
                          m_bal[i] = b - a;
                          r = {1'b1, 32'(m_bal[i])};
                      end
                3'd5: if (b + a <= 64'hFFFF_FFFF) begin
                          m_bal[i] = b + a;
                          r = {1'b1, 32'(m_bal[i])};
                      end
                3'd6: if (np >= 1000 && np <= 9999 && np != m_pin[i]) begin
                          m_pin[i] = np;
                          r = {1'b1, 32'(b)};
                      end
                default: r = {1'b0, 32'(b)};
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic chk_state(input string name, input logic [2:0] want);
        n_cmp++;
        if (state !== want) begin
            n_fail++;
            $display("FAIL %s: state got %0d, required %0d", name, state, want);
        end
    endtask

    task automatic chk_hold(input string name);
        n_cmp++;
        if (success !== prev_succ) begin
            n_fail++;
            $display("FAIL %s hold success: got %0b, required %0b", name, success, prev_succ);
        end
        if (prev_bal_known) begin
            n_cmp++;
            if (balance !== prev_bal) begin
                n_fail++;
                $display("FAIL %s hold balance: got %0d, required %0d", name, balance, prev_bal);
            end
        end
    endtask

    // One full transaction. Called with the next rising edge being IDLE->AUTH.
    task automatic do_txn(input string name, input logic [2:0] op, input logic [3:0] acc,
                          input logic [15:0] p, input logic [15:0] np,
                          input logic [31:0] amt, input logic lang);
        logic [32:0] r;
        logic [32:0] e;
        logic        auth_ok;
        logic        chk_bal;
        operation = op; acc_num = acc; pin = p; newPin = np; amount = amt; language = lang;
        model_txn(op, acc, p, np, amt, r, auth_ok);
        exp_q.push_back(r);
        // Rejected PIN changes leave the reported balance unconstrained.
        chk_bal = !(op == 3'd6 && auth_ok && !r[32]);

        @(posedge clk); #1;
        chk_state({name, " s_auth"}, 3'd0);
        chk_hold({name, " auth"});
        // Inputs are latched now; scrambling them must not matter.
        operation = 3'($urandom); acc_num = 4'($urandom); pin = 16'($urandom);
        newPin = 16'($urandom); amount = $urandom; language = 1'($urandom);

        @(posedge clk); #1;
        chk_state({name, " s_op"}, 3'd1);
        chk_hold({name, " op"});

        @(posedge clk); #1;
        chk_state({name, " s_done"}, 3'd2);
        e = exp_q.pop_front();
        n_cmp++;
        if (success !== e[32]) begin
            n_fail++;
            $display("FAIL %s success: got %0b, required %0b", name, success, e[32]);
        end
        if (chk_bal) begin
            n_cmp++;
            if (balance !== e[31:0]) begin
                n_fail++;
                $display("FAIL %s balance: got %0d, required %0d", name, balance, e[31:0]);
            end
        end
        prev_succ      = e[32];
        prev_bal       = e[31:0];
        prev_bal_known = chk_bal;

        @(posedge clk); #1;
        chk_state({name, " s_idle"}, 3'd7);
        chk_hold({name, " idle"});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        operation = 3'd3; acc_num = 4'd1; pin = 16'd1234; newPin = 16'd0;
        amount = 32'd0; language = 1'b0;
        @(posedge clk); #1;
        chk_state("reset", 3'd7);
        n_cmp++;
        if (success !== 1'b0) begin
            n_fail++;
            $display("FAIL reset success: got %0b, required 0", success);
        end
        n_cmp++;
        if (balance !== 32'd0) begin
            n_fail++;
            $display("FAIL reset balance: got %0d, required 0", balance);
        end
        prev_bal = 32'd0; prev_succ = 1'b0; prev_bal_known = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_balance_all();
        for (int n = 1; n <= 10; n++) begin
            do_txn("balance_all", 3'd3, 4'(n), m_pin[n-1], 16'd0, 32'd0, 1'(n));
        end
    endtask

    task automatic test_acc1_sequence();
        do_txn("acc1 wd_over", 3'd4, 4'd1, 16'd1234, 16'd0, 32'd1100, 1'b0);
        do_txn("acc1 dep",     3'd5, 4'd1, 16'd1234, 16'd0, 32'd1000, 1'b1);
        do_txn("acc1 wd",      3'd4, 4'd1, 16'd1234, 16'd0, 32'd500,  1'b0);
        n_cmp++;
        if (balance !== 32'd1500) begin
            n_fail++;
            $display("FAIL acc1 final balance: got %0d, required 1500", balance);
        end
        do_txn("acc1 zero_wd",  3'd4, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0);
        do_txn("acc1 zero_dep", 3'd5, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0);
    endtask

    task automatic test_bad_pin();
        do_txn("bad_pin",    3'd3, 4'd3, 16'd7123, 16'd0, 32'd0, 1'b0);
        do_txn("good_pin",   3'd3, 4'd3, 16'd3456, 16'd0, 32'd0, 1'b0);
        do_txn("acc0",       3'd3, 4'd0, 16'd1234, 16'd0, 32'd0, 1'b0);
        do_txn("acc11",      3'd3, 4'd11, 16'd1234, 16'd0, 32'd0, 1'b0);
        do_txn("bad_op",     3'd7, 4'd4, 16'd4567, 16'd0, 32'd0, 1'b0);
        do_txn("dep_ovf",    3'd5, 4'd5, 16'd5678, 16'd0, 32'hFFFF_F000, 1'b0);
        do_txn("dep_max",    3'd5, 4'd6, 16'd6789, 16'd0, 32'hFFFF_FFFF - 32'd6000, 1'b0);
    endtask

    task automatic test_pin_change();
        do_txn("pin same",   3'd6, 4'd1, 16'd1234, 16'd1234, 32'd0, 1'b0);
        do_txn("pin change", 3'd6, 4'd1, 16'd1234, 16'd5678, 32'd0, 1'b0);
        do_txn("pin old",    3'd3, 4'd1, 16'd1234, 16'd0,    32'd0, 1'b0);
        do_txn("pin new",    3'd3, 4'd1, 16'd5678, 16'd0,    32'd0, 1'b0);
        do_txn("pin low",    3'd6, 4'd2, 16'd2345, 16'd999,  32'd0, 1'b0);
        do_txn("pin high",   3'd6, 4'd2, 16'd2345, 16'd10000, 32'd0, 1'b0);
    endtask

    task automatic test_reset_abort();
        operation = 3'd5; acc_num = 4'd2; pin = 16'd2345; newPin = 16'd0;
        amount = 32'd1000; language = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_state("abort in_op", 3'd1);
        rst = 1'b0;
        #1;
        chk_state("abort async", 3'd7);
        n_cmp++;
        if (success !== 1'b0 || balance !== 32'd0) begin
            n_fail++;
            $display("FAIL abort outputs: got success=%0b balance=%0d, required 0/0", success, balance);
        end
        @(posedge clk); #1;
        chk_state("abort held", 3'd7);
        @(negedge clk);
        rst = 1'b1;
        prev_bal = 32'd0; prev_succ = 1'b0; prev_bal_known = 1'b1;
        do_txn("abort after", 3'd3, 4'd2, m_pin[1], 16'd0, 32'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [15:0] p;
        logic [15:0] np;
        logic [31:0] amt;
        for (int k = 0; k < 40; k++) begin
            op  = 3'($urandom_range(7, 0));
            if ($urandom_range(3, 0) != 0) op = 3'($urandom_range(6, 3));
            acc = 4'($urandom_range(15, 0));
            if ($urandom_range(4, 0) != 0) acc = 4'($urandom_range(10, 1));
            p = 16'($urandom);
            if (acc >= 1 && acc <= 10 && $urandom_range(3, 0) != 0) p = m_pin[int'(acc)-1];
            case ($urandom_range(2, 0))
                0: np = 16'($urandom_range(9999, 1000));
                1: np = 16'($urandom);
                default: np = (acc >= 1 && acc <= 10) ? m_pin[int'(acc)-1] : 16'd0;
            endcase
            case ($urandom_range(3, 0))
                0: amt = 32'd0;
                1: amt = 32'($urandom_range(4000, 1));
                2: amt = 32'hFFFF_FFFF - 32'($urandom_range(20000, 0));
                default: amt = $urandom;
            endcase
            do_txn("random", op, acc, p, np, amt, 1'($urandom));
        end
    endtask

    task automatic test_back_to_back_reset_recovery();
        // Table contents survive a reset; balances from before must persist.
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        prev_bal = 32'd0; prev_succ = 1'b0; prev_bal_known = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            do_txn("post_reset", 3'd3, 4'(n), m_pin[n-1], 16'd0, 32'd0, 1'b0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_init();
        test_reset();
        test_balance_all();
        test_acc1_sequence();
        test_bad_pin();
        test_pin_change();
        test_reset_abort();
        test_random();
        test_back_to_back_reset_recovery();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
